// File: rtl/tim1_evt_ctrl.sv
// tim1_evt_ctrl: basic up-counting timer core with prescaler, auto-reload,
// preload shadows, software update/compare generation and sticky flags.
// Every output comes straight from a flop, so effects show up the cycle
// after the edge that caused them.
module tim1_evt_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_ug,
  input  logic        i_cc1g,
  input  logic        i_cen,
  input  logic        i_udis,
  input  logic        i_urs,
  input  logic        i_arpe,
  input  logic [15:0] i_psc,
  input  logic [15:0] i_arr,
  input  logic [15:0] i_ccr1,
  input  logic        i_clr_uif,
  input  logic        i_clr_cc1if,
  output logic [15:0] o_cnt,
  output logic        o_uev,
  output logic        o_cc1_evt,
  output logic        o_uif,
  output logic        o_cc1if,
  output logic        o_ug_ack,
  output logic        o_cc1g_ack
);

  logic        ug_prev_q,    ug_prev_d;
  logic        cc1g_prev_q,  cc1g_prev_d;
  logic [15:0] psc_cnt_q,    psc_cnt_d;
  logic [15:0] cnt_q,        cnt_d;
  logic [15:0] psc_shadow_q, psc_shadow_d;
  logic [15:0] arr_shadow_q, arr_shadow_d;
  logic        uev_q,        uev_d;
  logic        cc1_evt_q,    cc1_evt_d;
  logic        uif_q,        uif_d;
  logic        cc1if_q,      cc1if_d;
  logic        ug_ack_q,     ug_ack_d;
  logic        cc1g_ack_q,   cc1g_ack_d;

  logic        ug_edge;
  logic        cc1g_edge;
  logic        tick;
  logic        ovf;
  logic [15:0] cnt_tick;
  logic        cmp_hit;
  logic        uev_now;
  logic        uif_set;
  logic        cc1_set;

  // Next-state logic for prescaler, counter, shadows, flags and pulses.
  always_comb begin
    ug_edge   = i_ug & ~ug_prev_q;
    cc1g_edge = i_cc1g & ~cc1g_prev_q;

    tick = i_cen && (psc_cnt_q == psc_shadow_q);
    ovf  = tick && (cnt_q == arr_shadow_q);

    cnt_tick = cnt_q;
    if (tick) begin
      cnt_tick = ovf ? 16'd0 : cnt_q + 16'd1;
    end

    psc_cnt_d = psc_cnt_q;
    if (i_cen) begin
      psc_cnt_d = tick ? 16'd0 : psc_cnt_q + 16'd1;
    end
    cnt_d = cnt_tick;

    // UG wins over a coincident overflow: counter restarts, one UEV at most.
    if (ug_edge) begin
      cnt_d     = 16'd0;
      psc_cnt_d = 16'd0;
      uev_now   = ~i_udis;
      uif_set   = ~i_udis & ~i_urs;
    end else begin
      uev_now   = ovf & ~i_udis;
      uif_set   = ovf & ~i_udis;
    end

    psc_shadow_d = uev_now ? i_psc : psc_shadow_q;
    arr_shadow_d = (!i_arpe || uev_now) ? i_arr : arr_shadow_q;

    // A UG restart overrides whatever value the tick would have produced.
    cmp_hit = tick && !ug_edge && (cnt_tick == i_ccr1);
    cc1_set = cmp_hit | cc1g_edge;

    uev_d      = uev_now;
    cc1_evt_d  = cc1_set;
    uif_d      = uif_set | (uif_q & ~i_clr_uif);
    cc1if_d    = cc1_set | (cc1if_q & ~i_clr_cc1if);
    ug_ack_d   = ug_edge;
    cc1g_ack_d = cc1g_edge;

    ug_prev_d   = i_ug;
    cc1g_prev_d = i_cc1g;
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ug_prev_q    <= 1'b0;
      cc1g_prev_q  <= 1'b0;
      psc_cnt_q    <= 16'd0;
      cnt_q        <= 16'd0;
      psc_shadow_q <= 16'd0;
      arr_shadow_q <= 16'd0;
      uev_q        <= 1'b0;
      cc1_evt_q    <= 1'b0;
      uif_q        <= 1'b0;
      cc1if_q      <= 1'b0;
      ug_ack_q     <= 1'b0;
      cc1g_ack_q   <= 1'b0;
    end else begin
      ug_prev_q    <= ug_prev_d;
      cc1g_prev_q  <= cc1g_prev_d;
      psc_cnt_q    <= psc_cnt_d;
      cnt_q        <= cnt_d;
      psc_shadow_q <= psc_shadow_d;
      arr_shadow_q <= arr_shadow_d;
      uev_q        <= uev_d;
      cc1_evt_q    <= cc1_evt_d;
      uif_q        <= uif_d;
      cc1if_q      <= cc1if_d;
      ug_ack_q     <= ug_ack_d;
      cc1g_ack_q   <= cc1g_ack_d;
    end
  end

  assign o_cnt      = cnt_q;
  assign o_uev      = uev_q;
  assign o_cc1_evt  = cc1_evt_q;
  assign o_uif      = uif_q;
  assign o_cc1if    = cc1if_q;
  assign o_ug_ack   = ug_ack_q;
  assign o_cc1g_ack = cc1g_ack_q;

endmodule

// File: tb/tb_tim1_evt_ctrl.sv
// Directed bench for tim1_evt_ctrl. Inputs change 1 ns after a rising edge;
// outputs are sampled at the same point, i.e. they show the effect of the
// edge that just happened.
module tb_tim1_evt_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_ug, i_cc1g, i_cen, i_udis, i_urs, i_arpe;
  logic [15:0] i_psc, i_arr, i_ccr1;
  logic        i_clr_uif, i_clr_cc1if;
  logic [15:0] o_cnt;
  logic        o_uev, o_cc1_evt, o_uif, o_cc1if, o_ug_ack, o_cc1g_ack;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  tim1_evt_ctrl dut (
    .clk(clk), .rst_n(rst_n), .i_ug(i_ug), .i_cc1g(i_cc1g), .i_cen(i_cen),
    .i_udis(i_udis), .i_urs(i_urs), .i_arpe(i_arpe), .i_psc(i_psc),
    .i_arr(i_arr), .i_ccr1(i_ccr1), .i_clr_uif(i_clr_uif),
    .i_clr_cc1if(i_clr_cc1if), .o_cnt(o_cnt), .o_uev(o_uev),
    .o_cc1_evt(o_cc1_evt), .o_uif(o_uif), .o_cc1if(o_cc1if),
    .o_ug_ack(o_ug_ack), .o_cc1g_ack(o_cc1g_ack)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; i_ug = 1'b1; i_cc1g = 1'b0; i_cen = 1'b0; i_udis = 1'b0;
    i_urs = 1'b0; i_arpe = 1'b0; i_psc = 16'd0; i_arr = 16'd3;
    i_ccr1 = 16'hFFFF; i_clr_uif = 1'b0; i_clr_cc1if = 1'b0;
    step(); step();
    n_vec++; if (o_cnt !== 16'd0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", o_cnt); end
    n_vec++; if ({o_uev, o_cc1_evt, o_uif, o_cc1if, o_ug_ack, o_cc1g_ack} !== 6'b0) begin
      n_err++; $display("FAIL reset_outs: got %b want 000000", {o_uev, o_cc1_evt, o_uif, o_cc1if, o_ug_ack, o_cc1g_ack}); end
    // i_ug was high through reset: first live edge is a UG edge
    rst_n = 1'b1;
    step();
    n_vec++; if ({o_ug_ack, o_uev, o_uif} !== 3'b111) begin
      n_err++; $display("FAIL reset_ug_held: got ack/uev/uif %b want 111", {o_ug_ack, o_uev, o_uif}); end
    step();
    n_vec++; if ({o_ug_ack, o_uev} !== 2'b00) begin
      n_err++; $display("FAIL ug_level_noretrig: got ack/uev %b want 00", {o_ug_ack, o_uev}); end
    i_ug = 1'b0;
    step();
  endtask

  task automatic test_count();
    logic [15:0] exp_cnt [8] = '{16'd0, 16'd1, 16'd1, 16'd2, 16'd2, 16'd3, 16'd3, 16'd0};
    i_psc = 16'd1; i_arr = 16'd3; i_ug = 1'b1;
    step();
    n_vec++; if (o_ug_ack !== 1'b1) begin n_err++; $display("FAIL count_ug_ack: got %b want 1", o_ug_ack); end
    i_ug = 1'b0; i_clr_uif = 1'b1;
    step();
    i_clr_uif = 1'b0;
    n_vec++; if (o_uif !== 1'b0) begin n_err++; $display("FAIL count_clr_uif: got %b want 0", o_uif); end
    n_vec++; if (o_cnt !== 16'd0) begin n_err++; $display("FAIL count_start: got %0d want 0", o_cnt); end
    i_cen = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      n_vec++; if (o_cnt !== exp_cnt[k]) begin n_err++; $display("FAIL count_seq[%0d]: got %0d want %0d", k, o_cnt, exp_cnt[k]); end
      n_vec++; if (o_uev !== (k == 7)) begin n_err++; $display("FAIL count_uev[%0d]: got %b want %b", k, o_uev, (k == 7)); end
      n_vec++; if (o_uif !== (k == 7)) begin n_err++; $display("FAIL count_uif[%0d]: got %b want %b", k, o_uif, (k == 7)); end
    end
    i_cen = 1'b0;
  endtask

  task automatic test_arpe();
    logic [15:0] exp_a [10] = '{16'd1, 16'd2, 16'd3, 16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd0};
    logic [15:0] exp_b [4]  = '{16'd1, 16'd2, 16'd3, 16'd0};
    i_psc = 16'd0; i_arpe = 1'b1; i_ug = 1'b1;
    step();
    i_ug = 1'b0; i_clr_uif = 1'b1;
    step();
    i_clr_uif = 1'b0; i_cen = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (k == 2) i_arr = 16'd5;
      step();
      n_vec++; if (o_cnt !== exp_a[k]) begin n_err++; $display("FAIL arpe1_cnt[%0d]: got %0d want %0d", k, o_cnt, exp_a[k]); end
      n_vec++; if (o_uev !== (k == 3 || k == 9)) begin n_err++; $display("FAIL arpe1_uev[%0d]: got %b want %b", k, o_uev, (k == 3 || k == 9)); end
    end
    i_arpe = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k == 2) i_arr = 16'd3;
      step();
      n_vec++; if (o_cnt !== exp_b[k]) begin n_err++; $display("FAIL arpe0_cnt[%0d]: got %0d want %0d", k, o_cnt, exp_b[k]); end
    end
    n_vec++; if (o_uev !== 1'b1) begin n_err++; $display("FAIL arpe0_uev: got %b want 1", o_uev); end
    i_cen = 1'b0;
  endtask

  task automatic test_ug_modes();
    i_clr_uif = 1'b1;
    step();
    i_clr_uif = 1'b0; i_urs = 1'b1; i_ug = 1'b1;
    step();
    n_vec++; if ({o_uev, o_uif, o_ug_ack} !== 3'b101) begin
      n_err++; $display("FAIL ug_urs1: got uev/uif/ack %b want 101", {o_uev, o_uif, o_ug_ack}); end
    step();
    n_vec++; if ({o_uev, o_ug_ack} !== 2'b00) begin
      n_err++; $display("FAIL ug_ack_width: got uev/ack %b want 00", {o_uev, o_ug_ack}); end
    i_ug = 1'b0; i_urs = 1'b0; i_cen = 1'b1;
    step(); step();
    i_cen = 1'b0;
    step();
    n_vec++; if (o_cnt !== 16'd2) begin n_err++; $display("FAIL cen0_hold: got %0d want 2", o_cnt); end
    i_psc = 16'd1; i_udis = 1'b1; i_ug = 1'b1;
    step();
    n_vec++; if (o_cnt !== 16'd0) begin n_err++; $display("FAIL ug_udis_cnt: got %0d want 0", o_cnt); end
    n_vec++; if ({o_uev, o_uif, o_ug_ack} !== 3'b001) begin
      n_err++; $display("FAIL ug_udis_flags: got uev/uif/ack %b want 001", {o_uev, o_uif, o_ug_ack}); end
    // prescaler shadow must still be 0, so the counter moves every cycle
    i_ug = 1'b0; i_udis = 1'b0; i_psc = 16'd0; i_cen = 1'b1;
    step();
    n_vec++; if (o_cnt !== 16'd1) begin n_err++; $display("FAIL ug_udis_noload: got %0d want 1", o_cnt); end
    i_cen = 1'b0;
  endtask

  task automatic test_cc1();
    int acks = 0;
    int evts = 0;
    i_ug = 1'b1;
    step();
    i_ug = 1'b0;
    step();
    i_ccr1 = 16'd2; i_cen = 1'b1;
    step();
    n_vec++; if ({o_cc1if, o_cc1_evt} !== 2'b00) begin n_err++; $display("FAIL cc1_at1: got if/evt %b want 00", {o_cc1if, o_cc1_evt}); end
    step();
    n_vec++; if ({o_cc1if, o_cc1_evt} !== 2'b11) begin n_err++; $display("FAIL cc1_at2: got if/evt %b want 11", {o_cc1if, o_cc1_evt}); end
    step();
    n_vec++; if ({o_cc1if, o_cc1_evt} !== 2'b10) begin n_err++; $display("FAIL cc1_at3: got if/evt %b want 10", {o_cc1if, o_cc1_evt}); end
    i_cen = 1'b0; i_clr_cc1if = 1'b1;
    step();
    i_clr_cc1if = 1'b0;
    n_vec++; if (o_cc1if !== 1'b0) begin n_err++; $display("FAIL cc1_clr: got %b want 0", o_cc1if); end
    i_cc1g = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      if (o_cc1g_ack === 1'b1) acks++;
      if (o_cc1_evt === 1'b1) evts++;
    end
    n_vec++; if (acks !== 1) begin n_err++; $display("FAIL cc1g_acks: got %0d want 1", acks); end
    n_vec++; if (evts !== 1) begin n_err++; $display("FAIL cc1g_evts: got %0d want 1", evts); end
    n_vec++; if (o_cc1if !== 1'b1) begin n_err++; $display("FAIL cc1g_flag: got %b want 1", o_cc1if); end
    i_cc1g = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    int uevs = 0;
    i_ug = 1'b1;
    step();
    i_ug = 1'b0; i_cen = 1'b1;
    step(); step(); step();
    i_clr_uif = 1'b1;
    step();
    i_clr_uif = 1'b0;
    n_vec++; if ({o_cnt, o_uev, o_uif} !== {16'd0, 2'b11}) begin
      n_err++; $display("FAIL clr_vs_ovf: got cnt %0d uev %b uif %b want 0 1 1", o_cnt, o_uev, o_uif); end
    i_cen = 1'b0; i_clr_uif = 1'b1;
    step();
    i_clr_uif = 1'b0;
    n_vec++; if (o_uif !== 1'b0) begin n_err++; $display("FAIL uif_clr2: got %b want 0", o_uif); end
    i_cen = 1'b1;
    step(); step(); step();
    i_ug = 1'b1;
    step();
    if (o_uev === 1'b1) uevs++;
    n_vec++; if ({o_cnt, o_ug_ack} !== {16'd0, 1'b1}) begin
      n_err++; $display("FAIL ug_on_ovf: got cnt %0d ack %b want 0 1", o_cnt, o_ug_ack); end
    i_ug = 1'b0;
    step();
    if (o_uev === 1'b1) uevs++;
    n_vec++; if (uevs !== 1) begin n_err++; $display("FAIL ug_on_ovf_uevs: got %0d want 1", uevs); end
    n_vec++; if (o_cnt !== 16'd1) begin n_err++; $display("FAIL ug_on_ovf_next: got %0d want 1", o_cnt); end
    i_clr_cc1if = 1'b1;
    step();
    i_clr_cc1if = 1'b0;
    n_vec++; if ({o_cnt, o_cc1if} !== {16'd2, 1'b1}) begin
      n_err++; $display("FAIL clr_vs_cmp: got cnt %0d cc1if %b want 2 1", o_cnt, o_cc1if); end
  endtask

  task automatic test_reset_midcount();
    step();
    n_vec++; if (o_cnt !== 16'd3) begin n_err++; $display("FAIL pre_reset_cnt: got %0d want 3", o_cnt); end
    rst_n = 1'b0;
    step();
    n_vec++; if ({o_cnt, o_uif, o_cc1if, o_uev, o_cc1_evt} !== {16'd0, 4'b0000}) begin
      n_err++; $display("FAIL midcount_reset: got cnt %0d uif %b cc1if %b uev %b evt %b want 0 0 0 0 0", o_cnt, o_uif, o_cc1if, o_uev, o_cc1_evt); end
    i_cen = 1'b0; rst_n = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_count();
    test_arpe();
    test_ug_modes();
    test_cc1();
    test_back_to_back();
    test_reset_midcount();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tim1_evt_ctrl.md
TIM1_EVT_CTRL -- requirements
Module: tim1_evt_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n, input, 1, synchronous active-low reset, sampled on clk rising edge.
REQ-003 SHALL have port i_ug, input, 1, update-generation request level from the EGR register.
REQ-004 SHALL have port i_cc1g, input, 1, capture/compare-1 generation request level from the EGR register.
REQ-005 SHALL have port i_cen, input, 1, counter enable.
REQ-006 SHALL have port i_udis, input, 1, update disable.
REQ-007 SHALL have port i_urs, input, 1, update request source (1 = only overflow sets UIF).
REQ-008 SHALL have port i_arpe, input, 1, auto-reload preload enable.
REQ-009 SHALL have ports i_psc, i_arr, i_ccr1, input, 16 each, prescaler, auto-reload and compare preload values.
REQ-010 SHALL have ports i_clr_uif, i_clr_cc1if, input, 1 each, software flag-clear strobes.
REQ-011 SHALL have port o_cnt, output, 16, counter value.
REQ-012 SHALL have ports o_uev, o_cc1_evt, output, 1 each, one-cycle update and CC1 event pulses.
REQ-013 SHALL have ports o_uif, o_cc1if, output, 1 each, sticky status flags.
REQ-014 SHALL have ports o_ug_ack, o_cc1g_ack, output, 1 each, one-cycle acknowledges that let EGR bits be cleared.

Function
REQ-015 SHALL detect requests on the rising edge of i_ug/i_cc1g against a registered previous value; a held-high level SHALL NOT retrigger.
REQ-016 SHALL, on a cycle with i_cen=1, increment the 16-bit prescaler count; when it equals psc_shadow, it SHALL wrap to 0 and issue an internal tick. psc_shadow=0 SHALL tick every enabled cycle.
REQ-017 SHALL, on tick: if o_cnt==arr_shadow, set o_cnt to 0 and raise overflow; otherwise increment o_cnt. arr_shadow=0 SHALL overflow on every tick.
REQ-018 SHALL track arr_shadow to i_arr every cycle when i_arpe=0. When i_arpe=1, arr_shadow SHALL load only on UEV. psc_shadow SHALL load only on UEV.
REQ-019 SHALL generate UEV on overflow when i_udis=0, pulsing o_uev, setting o_uif and loading the shadows in the same edge.
REQ-020 SHALL, on a UG edge, clear o_cnt and the prescaler count on the next clk edge and pulse o_ug_ack one cycle regardless of i_udis.
REQ-021 SHALL, on a UG edge with i_udis=0, also generate UEV (o_uev, shadow load), setting o_uif only if i_urs=0.
REQ-022 SHALL, on a UG edge with i_udis=1, perform no shadow load, no o_uev and no o_uif.
REQ-023 SHALL let UG take priority when UG and overflow coincide: exactly one o_uev pulse, o_cnt=0.
REQ-024 SHALL set o_cc1if and pulse o_cc1_evt when a tick moves o_cnt to a value equal to i_ccr1.
REQ-025 SHALL set o_cc1if, pulse o_cc1_evt and pulse o_cc1g_ack on a CC1G edge; coincident compare and CC1G SHALL give a single pulse.
REQ-026 SHALL make all outputs registered, with effects visible the cycle after the triggering edge.
REQ-027 SHALL let set win when a flag's set and clear strobe coincide.
REQ-028 SHALL, with i_cen=0, hold counter and prescaler; UG and CC1G SHALL still act.

Reset
REQ-029 SHALL, with rst_n=0 at a clk edge, clear o_cnt, prescaler count, psc_shadow, arr_shadow, edge registers, o_uif and o_cc1if, and drive all pulses to 0.
REQ-030 SHALL let reset abort any in-progress count; the first edge with rst_n=1 and i_ug=1 held SHALL count as a UG edge.

Verification
REQ-031 SHALL be verified by: i_psc=1, i_arr=3, UG pulse, clear UIF, i_cen=1 -> o_cnt 0,0,1,1,2,2,3,3,0; o_uev and o_uif at the 3->0 wrap.
REQ-032 SHALL be verified by: i_arpe=1, i_arr changed 3->5 mid-period -> wrap still at 3, then wrap at 5; i_arpe=0 -> change takes effect immediately.
REQ-033 SHALL be verified by: UG with i_urs=1 -> o_uev=1, o_uif stays 0, o_ug_ack one cycle. UG with i_udis=1 -> o_cnt=0, no o_uev.
REQ-034 SHALL be verified by: i_ccr1=2, count through 2 -> o_cc1if=1, one o_cc1_evt. i_cc1g held high 5 cycles -> single o_cc1g_ack.
REQ-035 SHALL be verified by: i_clr_uif coincident with overflow -> o_uif=1. UG on overflow cycle -> one o_uev.
REQ-036 SHALL be verified by: rst_n=0 while o_cnt=3 -> next cycle o_cnt=0 and all flags 0.
